// File: rtl/lpgbt_fec_pkg.sv
// Shared GF(2^3) constants and helpers for the lpGBT downlink RS(7,5) decoder.
package lpgbt_fec_pkg;

    localparam int         GF8_W    = 3;
    localparam logic [3:0] GF8_PRIM = 4'b1011;

    localparam logic [GF8_W-1:0] ALPHA_POW [0:6] = '{
        3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101
    };

    localparam int RS_DN_N = 7;
    localparam int RS_DN_K = 5;

    typedef logic [GF8_W-1:0] gf8_t;

    typedef struct packed {
        gf8_t s1;
        gf8_t s2;
        logic err;
    } synd_t;

    // x*a: shift left and fold the overflow bit back through the low terms of the primitive poly
    function automatic gf8_t gf8_mul_alpha(input gf8_t a);
        return {a[GF8_W-2:0], 1'b0} ^ (a[GF8_W-1] ? GF8_PRIM[GF8_W-1:0] : gf8_t'(0));
    endfunction

endpackage

// File: rtl/rs7_5_syndrome_serial_gf.sv
// GF(2^3) building blocks: constant multiply by alpha^POW and field addition.
module gf_mul_alpha_3
    import lpgbt_fec_pkg::*;
#(
    parameter int POW = 1
) (
    input  logic [GF8_W-1:0] a,
    output logic [GF8_W-1:0] y
);

    always_comb begin
        y = a;
        for (int i = 0; i < POW; i++) begin
            y = gf8_mul_alpha(y);
        end
    end

endmodule

module gf_add_3
    import lpgbt_fec_pkg::*;
(
    input  logic [GF8_W-1:0] a,
    input  logic [GF8_W-1:0] b,
    output logic [GF8_W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/rs7_5_syndrome_serial.sv
// Serial Horner-rule syndrome stage (S1, S2) of the RS(7,5) downlink decoder with a
// one-entry valid/ready output slice and a saturating error-frame counter.
module rs7_5_syndrome_serial
    import lpgbt_fec_pkg::*;
#(
    parameter int N_SYM     = 7,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [GF8_W-1:0]     sym_i,
    input  logic                 sym_valid_i,
    input  logic                 sym_sof_i,
    output logic                 sym_ready_o,
    output logic [GF8_W-1:0]     synd1_o,
    output logic [GF8_W-1:0]     synd2_o,
    output logic                 synd_err_o,
    output logic                 synd_valid_o,
    input  logic                 synd_ready_i,
    output logic                 abort_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int               IDX_W    = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SYM - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [IDX_W-1:0] idx;
    logic [0:0]       state;
    gf8_t             s1, s2;
    gf8_t             s1_sh, s2_sh, s1_fb, s2_fb, s1_nxt, s2_nxt;
    synd_t            slice;

    logic acc, restart, at_last, complete, consume, abort_nxt, err_nxt;

    gf_mul_alpha_3 #(.POW(1)) u_mul1 (.a(s1), .y(s1_sh));
    gf_mul_alpha_3 #(.POW(2)) u_mul2 (.a(s2), .y(s2_sh));

    gf_add_3 u_add1 (.a(s1_sh), .b(sym_i), .y(s1_fb));
    gf_add_3 u_add2 (.a(s2_sh), .b(sym_i), .y(s2_fb));

    assign at_last     = (idx == IDX_LAST);
    assign consume     = synd_valid_o & synd_ready_i;
    // Only the completing symbol has to wait for room in the slice
    assign sym_ready_o = !(synd_valid_o && !synd_ready_i && at_last);
    assign acc         = sym_valid_i & sym_ready_o;

    assign restart   = sym_sof_i || (idx == '0);
    assign complete  = acc && at_last && !sym_sof_i;
    assign abort_nxt = acc && sym_sof_i && (idx != '0);

    assign s1_nxt  = restart ? sym_i : s1_fb;
    assign s2_nxt  = restart ? sym_i : s2_fb;
    assign err_nxt = (s1_nxt | s2_nxt) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            s1  <= '0;
            s2  <= '0;
        end else if (acc) begin
            s1 <= s1_nxt;
            s2 <= s2_nxt;
            if (sym_sof_i)
                idx <= IDX_W'(1);
            else if (at_last)
                idx <= '0;
            else
                idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            slice <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (complete) state <= ST_FULL;
                ST_FULL:  if (consume && !complete) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
            if (complete)
                slice <= '{s1: s1_nxt, s2: s2_nxt, err: err_nxt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_o   <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            abort_o <= abort_nxt;
            if (complete && err_nxt && (err_cnt_o != '1))
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    assign synd_valid_o = (state == ST_FULL);
    assign synd1_o      = slice.s1;
    assign synd2_o      = slice.s2;
    assign synd_err_o   = slice.err;

endmodule

// File: tb/tb_rs7_5_syndrome_serial.sv
// Randomised bench for rs7_5_syndrome_serial against a GF(2^3) polynomial-evaluation model.
module tb_rs7_5_syndrome_serial;

    localparam int N    = 7;
    localparam int ERRW = 4;
    localparam int CMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      sym;
    logic            sym_valid, sym_sof;
    wire             sym_ready;
    wire  [2:0]      synd1, synd2;
    wire             synd_err, synd_valid, abort;
    wire             synd_ready;
    wire  [ERRW-1:0] err_cnt;

    int cyc = 0;
    int stall_lo = 0, stall_hi = 0;
    assign synd_ready = !(cyc >= stall_lo && cyc < stall_hi);

    rs7_5_syndrome_serial #(.N_SYM(N), .ERR_CNT_W(ERRW)) dut (
        .clk(clk), .rst(rst), .sym_i(sym), .sym_valid_i(sym_valid), .sym_sof_i(sym_sof),
        .sym_ready_o(sym_ready), .synd1_o(synd1), .synd2_o(synd2), .synd_err_o(synd_err),
        .synd_valid_o(synd_valid), .synd_ready_i(synd_ready), .abort_o(abort), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records consumed results and watches slice stability / stalls / aborts
    logic [6:0] got [0:511];
    int         gn = 0, hold_viol = 0, stall_seen = 0, abort_n = 0;
    logic       pend = 1'b0;
    logic [6:0] pv = '0;
    always @(negedge clk) begin
        if (pend && synd_valid && {synd1, synd2, synd_err} !== pv) hold_viol <= hold_viol + 1;
        pend <= synd_valid && !synd_ready;
        pv   <= {synd1, synd2, synd_err};
        if (synd_valid && synd_ready && !rst) begin
            got[gn] <= {synd1, synd2, synd_err};
            gn      <= gn + 1;
        end
        if (sym_valid && !sym_ready) stall_seen <= stall_seen + 1;
        if (abort) abort_n <= abort_n + 1;
    end

    int           checks = 0, errors = 0;
    int           rd = 0, model_cnt = 0;
    logic [6:0]   exp_q [$];
    logic [2:0]   fr [0:N-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) if (b[i]) p = p ^ ({3'b000, a} << i);
        for (int k = 4; k >= 3; k--) if (p[k]) p = p ^ (6'b001011 << (k - 3));
        return p[2:0];
    endfunction

    function automatic logic [2:0] apow(input int e);
        logic [2:0] x;
        x = 3'd1;
        for (int i = 0; i < e % 7; i++) x = gmul(x, 3'd2);
        return x;
    endfunction

    // r(x) = sum fr[j] * x^(N-1-j), evaluated at alpha^pw
    function automatic logic [2:0] synd(input int pw);
        logic [2:0] s;
        s = '0;
        for (int j = 0; j < N; j++) s = s ^ gmul(fr[j], apow(pw * (N - 1 - j)));
        return s;
    endfunction

    task automatic expect_frame();
        logic [2:0] a, b;
        logic       e;
        a = synd(1);
        b = synd(2);
        e = (a != 0) || (b != 0);
        exp_q.push_back({a, b, e});
        if (e && model_cnt < CMAX) model_cnt++;
    endtask

    task automatic drive_sym(input logic [2:0] s, input logic sof);
        int tries;
        tries     = 0;
        sym       = s;
        sym_sof   = sof;
        sym_valid = 1'b1;
        while (!sym_ready && tries < 40) begin
            @(posedge clk); #1;
            tries++;
        end
        if (tries >= 40) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: observed stalled %0d cycles expected < 40", tries);
        end
        @(posedge clk); #1;
        sym_valid = 1'b0;
        sym_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic sof_first);
        for (int j = 0; j < N; j++) drive_sym(fr[j], sof_first && j == 0);
    endtask

    task automatic rand_frame();
        for (int j = 0; j < N; j++) fr[j] = 3'($urandom_range(0, 7));
    endtask

    task automatic zero_frame();
        for (int j = 0; j < N; j++) fr[j] = 3'd0;
    endtask

    task automatic drain(input string tag);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_count"}, gn - rd, exp_q.size());
        while (exp_q.size() > 0 && rd < gn) begin
            check(tag, got[rd], exp_q.pop_front());
            rd++;
        end
        exp_q.delete();
        rd = gn;
        check({tag, "_errcnt"}, err_cnt, model_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ss0, ab0;
        logic [6:0] held;
        rst = 1'b1; sym = '0; sym_valid = 1'b0; sym_sof = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", synd_valid, 0);
        check("rst_synd", {synd1, synd2, synd_err}, 0);
        check("rst_abort", abort, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_ready", sym_ready, 1);

        // 1: all-zero frame, result visible right after the last symbol
        zero_frame();
        send_frame(1'b0);
        check("t1_valid", synd_valid, 1);
        check("t1_synd", {synd1, synd2, synd_err}, 7'b000_000_0);
        expect_frame();
        drain("t1");

        // 2: r0 = 1
        zero_frame(); fr[N-1] = 3'd1;
        send_frame(1'b0);
        check("t2_synd", {synd1, synd2, synd_err}, 7'b001_001_1);
        expect_frame();
        check("t2_errcnt", err_cnt, 1);
        drain("t2");

        // 3: r6 = 1
        zero_frame(); fr[0] = 3'd1;
        send_frame(1'b0);
        check("t3_synd", {synd1, synd2, synd_err}, 7'b101_111_1);
        expect_frame();
        drain("t3");

        // random frames back to back
        for (int f = 0; f < 6; f++) begin
            rand_frame();
            send_frame(f[0]);
            expect_frame();
        end
        drain("rand");

        // 4: three frames back to back, consumer stalls across frame 2
        rand_frame(); send_frame(1'b0); expect_frame();
        held = {synd1, synd2, synd_err};
        ss0 = stall_seen;
        stall_lo = cyc; stall_hi = cyc + 8;
        rand_frame();
        for (int j = 0; j < N - 1; j++) drive_sym(fr[j], 1'b0);
        check("t4_ready_low", sym_ready, 0);
        check("t4_held", {synd1, synd2, synd_err}, held);
        drive_sym(fr[N-1], 1'b0);
        expect_frame();
        rand_frame(); send_frame(1'b0); expect_frame();
        drain("t4");
        check("t4_stalled", stall_seen > ss0, 1);
        check("t4_hold_viol", hold_viol, 0);

        // 5: sof at idx=3 discards the partial frame
        ab0 = abort_n;
        for (int j = 0; j < 3; j++) drive_sym(3'($urandom_range(1, 7)), 1'b0);
        rand_frame();
        drive_sym(fr[0], 1'b1);
        check("t5_abort_hi", abort, 1);
        drive_sym(fr[1], 1'b0);
        check("t5_abort_lo", abort, 0);
        for (int j = 2; j < N; j++) drive_sym(fr[j], 1'b0);
        expect_frame();
        drain("t5");
        check("t5_abort_cnt", abort_n - ab0, 1);

        // 6: reset at idx=4 with a result pending
        stall_lo = cyc; stall_hi = cyc + 1000;
        rand_frame(); fr[N-1] = fr[N-1] ^ 3'd1; send_frame(1'b0);
        for (int j = 0; j < 4; j++) drive_sym(3'($urandom_range(0, 7)), 1'b0);
        check("t6_pending", synd_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stall_hi = 0;
        model_cnt = 0; rd = gn;
        check("t6_valid", synd_valid, 0);
        check("t6_synd", {synd1, synd2, synd_err}, 0);
        check("t6_abort", abort, 0);
        check("t6_errcnt", err_cnt, 0);
        check("t6_ready", sym_ready, 1);
        rand_frame(); send_frame(1'b0); expect_frame();
        drain("t6");

        // 7: saturate the error counter, then one more error frame
        while (model_cnt < CMAX) begin
            rand_frame(); fr[N-1] = 3'($urandom_range(1, 7));
            for (int j = 0; j < N - 1; j++) fr[j] = 3'd0;
            send_frame(1'b0); expect_frame();
        end
        drain("t7_fill");
        zero_frame(); fr[N-1] = 3'd1;
        send_frame(1'b0); expect_frame();
        drain("t7_sat");
        check("t7_allones", err_cnt, CMAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
